mc_core_param: RTL

Parametrised multi-cycle core for the 9-bit ISA, with a configurable data width and PC width. It has an internal 4-entry register file and a req/ack data-memory handshake that tolerates wait states. The EXT prefix supplies full-width immediates. The core sits between the external PC/instruction-fetch unit and data memory, and drives PC overrides and completion status.

---
 rtl/mc_core_param.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_core_param.sv
// Parametrised multi-cycle core for the 9-bit ISA: 4-entry register file, EXT prefix, req/ack data memory.
// Define CORE_PERF_CNT_EN to add the cyc_cnt/instr_cnt performance counters.
module mc_core_param #(
    parameter int DW  = 8,
    parameter int PCW = 8,
    parameter int AW  = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [8:0]     instr,
    input  logic [PCW-1:0] pc,
    input  logic [DW-1:0]  ext_data,
    output logic           mem_req,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata,
    input  logic           mem_ack,
    output logic           pc_load,
    output logic [PCW-1:0] pc_target,
    output logic           carry,
    output logic           done,
    output logic [1:0]     state_out
`ifdef CORE_PERF_CNT_EN
    ,
    output logic [31:0]    cyc_cnt,
    output logic [31:0]    instr_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXECUTE = 2'd1,
        S_MEM     = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BNE  = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_J    = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;
    localparam logic [3:0] OP_EXT  = 4'hE;

    state_t state, state_nxt;

    logic [3:0][DW-1:0] regs;
    logic               ext_pending;
    logic [1:0]         ext_rd;
    logic [DW-1:0]      ext_val;
    logic [1:0]         mem_rd;
    logic [1:0]         mem_rs;
    logic               mem_is_st;

    logic [3:0]     opcode;
    logic [1:0]     rd;
    logic [1:0]     rs;
    logic [2:0]     imm3;
    logic [4:0]     off5;
    logic [DW-1:0]  rd_val;
    logic [DW-1:0]  rs_val;
    logic [DW:0]    sum_full;
    logic [DW:0]    diff_full;
    logic [DW-1:0]  addi_val;
    logic [PCW-1:0] br_target;

    logic           rf_we;
    logic [1:0]     rf_wsel;
    logic [DW-1:0]  rf_wdata;
    logic           carry_we;
    logic           carry_nxt;
    logic           pc_load_nxt;
    logic [PCW-1:0] pc_target_nxt;
    logic           ext_set;
    logic           ext_clr;
    logic           done_set;
    logic           mem_latch;

    assign opcode    = instr[8:5];
    assign rd        = instr[4:3];
    assign rs        = instr[2:1];
    assign imm3      = instr[2:0];
    assign off5      = instr[4:0];
    assign rd_val    = regs[rd];
    assign rs_val    = regs[rs];
    assign sum_full  = {1'b0, rd_val} + {1'b0, rs_val};
    assign diff_full = {1'b0, rd_val} - {1'b0, rs_val};
    assign addi_val  = rs_val + {{(DW-3){imm3[2]}}, imm3};
    assign br_target = pc + {{(PCW-5){off5[4]}}, off5};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Decode and sequencing; every architectural update is requested here and applied below.
    always_comb begin
        state_nxt     = state;
        rf_we         = 1'b0;
        rf_wsel       = rd;
        rf_wdata      = '0;
        carry_we      = 1'b0;
        carry_nxt     = carry;
        pc_load_nxt   = 1'b0;
        pc_target_nxt = '0;
        ext_set       = 1'b0;
        ext_clr       = 1'b0;
        done_set      = 1'b0;
        mem_latch     = 1'b0;
        case (state)
            S_FETCH: begin
                if (!start) begin
                    state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_nxt = S_FETCH;
                case (opcode)
                    OP_ADD: begin
                        rf_we     = 1'b1;
                        rf_wdata  = sum_full[DW-1:0];
                        carry_we  = 1'b1;
                        carry_nxt = sum_full[DW];
                    end
                    OP_SUB: begin
                        rf_we     = 1'b1;
                        rf_wdata  = diff_full[DW-1:0];
                        carry_we  = 1'b1;
                        carry_nxt = diff_full[DW];
                    end
                    OP_AND: begin
                        rf_we    = 1'b1;
                        rf_wdata = rd_val & rs_val;
                    end
                    OP_OR: begin
                        rf_we    = 1'b1;
                        rf_wdata = rd_val | rs_val;
                    end
                    OP_XOR: begin
                        rf_we    = 1'b1;
                        rf_wdata = rd_val ^ rs_val;
                    end
                    OP_SHL: begin
                        rf_we     = 1'b1;
                        rf_wdata  = {rd_val[DW-2:0], 1'b0};
                        carry_we  = 1'b1;
                        carry_nxt = rd_val[DW-1];
                    end
                    OP_LDI: begin
                        rf_we = 1'b1;
                        // A pending EXT only applies to the LDI naming the same register.
                        if (ext_pending && (ext_rd == rd)) begin
                            rf_wdata = ext_val;
                            ext_clr  = 1'b1;
                        end else begin
                            rf_wdata = {{(DW-3){1'b0}}, imm3};
                        end
                    end
                    OP_ADDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = addi_val;
                    end
                    OP_LD, OP_ST: begin
                        mem_latch = 1'b1;
                        state_nxt = S_MEM;
                    end
                    OP_BNE: begin
                        if (rs_val != '0) begin
                            pc_load_nxt   = 1'b1;
                            pc_target_nxt = br_target;
                        end
                    end
                    OP_BEQ: begin
                        if (rs_val == '0) begin
                            pc_load_nxt   = 1'b1;
                            pc_target_nxt = br_target;
                        end
                    end
                    OP_J: begin
                        pc_load_nxt   = 1'b1;
                        pc_target_nxt = {{(PCW-5){1'b0}}, off5};
                    end
                    OP_HALT: begin
                        done_set  = 1'b1;
                        state_nxt = S_HALTED;
                    end
                    OP_EXT: begin
                        ext_set = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_nxt = S_FETCH;
                    if (!mem_is_st) begin
                        rf_we    = 1'b1;
                        rf_wsel  = mem_rd;
                        rf_wdata = mem_rdata;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else if (rf_we) begin
            regs[rf_wsel] <= rf_wdata;
        end
    end

    // Register indices are captured at LD/ST issue so address and write data hold through wait states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry       <= 1'b0;
            done        <= 1'b0;
            ext_pending <= 1'b0;
            ext_rd      <= '0;
            ext_val     <= '0;
            pc_load     <= 1'b0;
            pc_target   <= '0;
            mem_rd      <= '0;
            mem_rs      <= '0;
            mem_is_st   <= 1'b0;
        end else begin
            pc_load   <= pc_load_nxt;
            pc_target <= pc_target_nxt;
            if (carry_we) begin
                carry <= carry_nxt;
            end
            if (done_set) begin
                done <= 1'b1;
            end
            if (ext_set) begin
                ext_pending <= 1'b1;
                ext_rd      <= rd;
                ext_val     <= ext_data;
            end else if (ext_clr) begin
                ext_pending <= 1'b0;
            end
            if (mem_latch) begin
                mem_rd    <= rd;
                mem_rs    <= rs;
                mem_is_st <= (opcode == OP_ST);
            end
        end
    end

    assign state_out = state;
    assign mem_req   = (state == S_MEM);
    assign mem_we    = mem_req && mem_is_st;
    assign mem_addr  = regs[mem_rs][AW-1:0];
    assign mem_wdata = regs[mem_rd];

`ifdef CORE_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else if (!done) begin
            if (cyc_cnt != 32'hFFFF_FFFF) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (state == S_EXECUTE) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
